// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states, opcodes
// and the datapath mux selects driven by the controller.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_JAL,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    SRC_A_PC     = 2'b00,
    SRC_A_OLD_PC = 2'b01,
    SRC_A_RS1    = 2'b10
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'b00,
    SRC_B_IMM  = 2'b01,
    SRC_B_FOUR = 2'b10
  } alu_src_b_t;

  typedef enum logic [1:0] {
    RES_ALU_OUT  = 2'b00,
    RES_MEM_DATA = 2'b01,
    RES_PC       = 2'b10
  } result_src_t;

  function automatic state_t decode_next(input logic [6:0] opcode);
    case (opcode)
      OP_R_TYPE:         return S_EXEC_R;
      OP_I_TYPE:         return S_EXEC_I;
      OP_LOAD, OP_STORE: return S_MEM_ADDR;
      OP_JAL:            return S_JAL;
      default:           return S_TRAP;
    endcase
  endfunction

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle. The controller is the master: it
// consumes opcode and mem_ready and drives every control strobe and select.
interface multicycle_ctrl_if;

  logic [6:0]               opcode;
  logic                     mem_ready;
  logic                     mem_req;
  logic                     mem_we;
  logic                     addr_src;
  logic                     ir_write;
  logic                     pc_write;
  logic                     pc_src;
  rv_ctrl_pkg::alu_src_a_t  alu_src_a;
  rv_ctrl_pkg::alu_src_b_t  alu_src_b;
  logic                     alud;
  logic                     reg_write;
  rv_ctrl_pkg::result_src_t result_src;
  logic                     instr_done;
  logic                     illegal;
  logic                     mem_timeout;

  modport master (
    input  opcode, mem_ready,
    output mem_req, mem_we, addr_src, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alud, reg_write, result_src,
           instr_done, illegal, mem_timeout
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_req, mem_we, addr_src, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alud, reg_write, result_src,
           instr_done, illegal, mem_timeout
  );

endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle RV32 subset (R/I ALU ops, load, store, JAL)
// with a bounded memory wait and a sticky trap that holds until reset.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus
);

  // The trap fires on the wait cycle whose increment would make the count
  // equal MEM_TIMEOUT; a mem_ready in that same cycle still wins.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_cnt_next;
  logic       r_illegal;
  logic       r_mem_timeout;
  logic       w_mem_wait;
  logic       w_wait_expired;
  logic       w_timeout_trap;

  assign w_mem_wait     = is_mem_state(r_state) && !bus.mem_ready;
  assign w_wait_expired = (r_wait_cnt == WAIT_LAST);
  assign w_timeout_trap = w_mem_wait && w_wait_expired;

  always_comb begin
    w_wait_cnt_next = r_wait_cnt;
    if (w_next_state != r_state) begin
      w_wait_cnt_next = '0;
    end else if (w_mem_wait) begin
      w_wait_cnt_next = r_wait_cnt + 8'd1;
    end
  end

  // NOTE: state uses non-blocking assignments; reset is sampled on the clock edge only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_FETCH;
      r_wait_cnt    <= '0;
      r_illegal     <= 1'b0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_next_state == S_TRAP) r_illegal     <= 1'b1;
      if (w_timeout_trap)         r_mem_timeout <= 1'b1;
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: begin
        if (bus.mem_ready)       w_next_state = S_DECODE;
        else if (w_wait_expired) w_next_state = S_TRAP;
      end
      S_DECODE:           w_next_state = decode_next(bus.opcode);
      S_EXEC_R, S_EXEC_I: w_next_state = S_ALU_WB;
      S_ALU_WB, S_MEM_WB,
      S_JAL:              w_next_state = S_FETCH;
      S_MEM_ADDR:         w_next_state = (bus.opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (bus.mem_ready)       w_next_state = S_MEM_WB;
        else if (w_wait_expired) w_next_state = S_TRAP;
      end
      S_MEM_WR: begin
        if (bus.mem_ready)       w_next_state = S_FETCH;
        else if (w_wait_expired) w_next_state = S_TRAP;
      end
      S_TRAP:             w_next_state = S_TRAP;
      default:            w_next_state = S_TRAP;
    endcase
  end

  always_comb begin
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.addr_src    = 1'b0;
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.pc_src      = 1'b0;
    bus.alu_src_a   = SRC_A_PC;
    bus.alu_src_b   = SRC_B_RS2;
    bus.alud        = 1'b0;
    bus.reg_write   = 1'b0;
    bus.result_src  = RES_ALU_OUT;
    bus.instr_done  = 1'b0;
    bus.illegal     = rst_n && r_illegal;
    bus.mem_timeout = rst_n && r_mem_timeout;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          bus.mem_req   = 1'b1;
          bus.alu_src_b = SRC_B_FOUR;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
          end
        end
        S_DECODE: begin
          bus.alu_src_a = SRC_A_OLD_PC;
          bus.alu_src_b = SRC_B_IMM;
        end
        S_EXEC_R: begin
          bus.alu_src_a = SRC_A_RS1;
          bus.alud      = 1'b1;
        end
        S_EXEC_I: begin
          bus.alu_src_a = SRC_A_RS1;
          bus.alu_src_b = SRC_B_IMM;
          bus.alud      = 1'b1;
        end
        S_ALU_WB: begin
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_MEM_ADDR: begin
          bus.alu_src_a = SRC_A_RS1;
          bus.alu_src_b = SRC_B_IMM;
        end
        S_MEM_RD: begin
          bus.mem_req  = 1'b1;
          bus.addr_src = 1'b1;
        end
        S_MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.result_src = RES_MEM_DATA;
          bus.instr_done = 1'b1;
        end
        S_MEM_WR: begin
          bus.mem_req    = 1'b1;
          bus.mem_we     = 1'b1;
          bus.addr_src   = 1'b1;
          bus.instr_done = bus.mem_ready;
        end
        S_JAL: begin
          bus.reg_write  = 1'b1;
          bus.result_src = RES_PC;
          bus.pc_write   = 1'b1;
          bus.pc_src     = 1'b1;
          bus.instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboarded bench: random instruction mix with random memory waits on a
// default controller, plus directed reset/trap cases and a MEM_TIMEOUT=4 unit.
module tb_multicycle_ctrl;
  import rv_ctrl_pkg::*;

  localparam int N_RANDOM = 60;

  typedef struct {
    int         latency;
    int         req_cnt;
    int         rw_cnt;
    int         rw_at;
    int         pcw_cnt;
    int         we_cnt;
    int         addr1_cnt;
    int         alud_at;
    logic [1:0] res_src;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_na;
  logic rst_nb;
  bit   mon_en;
  int   n_cmp;
  int   n_bad;

  exp_t       exp_q[$];
  int         wait_q[$];
  logic [6:0] op_q[$];

  multicycle_ctrl_if ifa ();
  multicycle_ctrl_if ifb ();

  multicycle_ctrl dut_a (
    .clk   (clk),
    .rst_n (rst_na),
    .bus   (ifa)
  );

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_nb),
    .bus   (ifb)
  );

  // {mem_req, mem_we, addr_src, ir_write, pc_write, pc_src, a[1:0], b[1:0],
  //  alud, reg_write, result_src[1:0], instr_done, illegal, mem_timeout}
  logic [16:0] outs_a;
  logic [16:0] outs_b;
  assign outs_a = {ifa.mem_req, ifa.mem_we, ifa.addr_src, ifa.ir_write, ifa.pc_write,
                   ifa.pc_src, ifa.alu_src_a, ifa.alu_src_b, ifa.alud, ifa.reg_write,
                   ifa.result_src, ifa.instr_done, ifa.illegal, ifa.mem_timeout};
  assign outs_b = {ifb.mem_req, ifb.mem_we, ifb.addr_src, ifb.ir_write, ifb.pc_write,
                   ifb.pc_src, ifb.alu_src_a, ifb.alu_src_b, ifb.alud, ifb.reg_write,
                   ifb.result_src, ifb.instr_done, ifb.illegal, ifb.mem_timeout};

  localparam logic [16:0] OUT_FETCH_GRANT = 17'h13100;
  localparam logic [16:0] OUT_DECODE      = 17'h00280;
  localparam logic [16:0] OUT_MEM_ADDR    = 17'h00480;
  localparam logic [16:0] OUT_TRAP        = 17'h00002;
  localparam logic [16:0] OUT_TRAP_TMO    = 17'h00003;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: cost of each instruction class from the latency table plus waits.
  function automatic exp_t model(input logic [6:0] op, input int wf, input int wd);
    exp_t e;
    bit   is_mem;
    bit   is_alu;
    is_mem = (op == OP_LOAD) || (op == OP_STORE);
    is_alu = (op == OP_R_TYPE) || (op == OP_I_TYPE);
    if (is_alu)              e.latency = 4 + wf;
    else if (op == OP_LOAD)  e.latency = 5 + wf + wd;
    else if (op == OP_STORE) e.latency = 4 + wf + wd;
    else                     e.latency = 3 + wf;
    e.req_cnt   = wf + 1 + (is_mem ? wd + 1 : 0);
    e.rw_cnt    = (op == OP_STORE) ? 0 : 1;
    e.rw_at     = (op == OP_STORE) ? 0 : e.latency;
    e.pcw_cnt   = (op == OP_JAL) ? 2 : 1;
    e.we_cnt    = (op == OP_STORE) ? wd + 1 : 0;
    e.addr1_cnt = is_mem ? wd + 1 : 0;
    e.alud_at   = is_alu ? wf + 3 : 0;
    e.res_src   = (op == OP_LOAD) ? 2'b01 : (op == OP_JAL) ? 2'b10 : 2'b00;
    return e;
  endfunction

  task automatic issue(input logic [6:0] op, input int wf, input int wd);
    op_q.push_back(op);
    wait_q.push_back(wf);
    if (op == OP_LOAD || op == OP_STORE) wait_q.push_back(wd);
    exp_q.push_back(model(op, wf, wd));
  endtask

  // Memory responder for dut_a: per-request wait counts from wait_q, opcode
  // presented on the fetch grant, random mem_ready noise when no request is up.
  initial begin : responder
    bit in_req;
    int waits_left;
    in_req     = 1'b0;
    waits_left = 0;
    forever begin
      @(negedge clk);
      if (!rst_na || !ifa.mem_req) begin
        if (!rst_na) in_req = 1'b0;
        ifa.mem_ready = 1'($urandom_range(0, 1));
      end else begin
        if (!in_req) begin
          in_req     = 1'b1;
          waits_left = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
        end
        if (waits_left == 0) begin
          ifa.mem_ready = 1'b1;
          in_req        = 1'b0;
          if (!ifa.addr_src) ifa.opcode = (op_q.size() != 0) ? op_q.pop_front() : OP_R_TYPE;
        end else begin
          ifa.mem_ready = 1'b0;
          waits_left--;
          if (!ifa.addr_src) ifa.opcode = 7'($urandom);
        end
      end
    end
  end

  initial begin : monitor
    int   cyc, req_cnt, rw_cnt, rw_at, pcw_cnt, we_cnt, addr1_cnt, alud_cnt, alud_at, irw_cnt;
    exp_t e;
    cyc = 0; req_cnt = 0; rw_cnt = 0; rw_at = 0; pcw_cnt = 0;
    we_cnt = 0; addr1_cnt = 0; alud_cnt = 0; alud_at = 0; irw_cnt = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!mon_en) begin
        cyc = 0; req_cnt = 0; rw_cnt = 0; rw_at = 0; pcw_cnt = 0;
        we_cnt = 0; addr1_cnt = 0; alud_cnt = 0; alud_at = 0; irw_cnt = 0;
      end else begin
        cyc++;
        if (ifa.mem_req)  req_cnt++;
        if (ifa.mem_we)   we_cnt++;
        if (ifa.mem_req && ifa.addr_src) addr1_cnt++;
        if (ifa.pc_write) pcw_cnt++;
        if (ifa.ir_write) irw_cnt++;
        if (ifa.reg_write) begin rw_cnt++; rw_at = cyc; end
        if (ifa.alud)      begin alud_cnt++; alud_at = cyc; end
        check("we_without_req", 32'(ifa.mem_we & ~ifa.mem_req), 0);
        check("no_trap_flags", 32'({ifa.illegal, ifa.mem_timeout}), 0);
        if (ifa.instr_done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_retire", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("latency",      cyc,       e.latency);
            check("mem_req_cyc",  req_cnt,   e.req_cnt);
            check("reg_write_n",  rw_cnt,    e.rw_cnt);
            check("reg_write_at", rw_at,     e.rw_at);
            check("pc_write_n",   pcw_cnt,   e.pcw_cnt);
            check("ir_write_n",   irw_cnt,   1);
            check("mem_we_n",     we_cnt,    e.we_cnt);
            check("addr_src1_n",  addr1_cnt, e.addr1_cnt);
            check("alud_at",      alud_at,   e.alud_at);
            check("alud_n",       alud_cnt,  (e.alud_at != 0) ? 1 : 0);
            check("result_src",   32'(ifa.result_src), 32'(e.res_src));
          end
          cyc = 0; req_cnt = 0; rw_cnt = 0; rw_at = 0; pcw_cnt = 0;
          we_cnt = 0; addr1_cnt = 0; alud_cnt = 0; alud_at = 0; irw_cnt = 0;
        end else if (cyc > 40) begin
          check("retire_watchdog", cyc, 40);
          cyc = 0;
        end
      end
    end
  end

  initial begin : safety
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : main
    bit found;
    n_cmp = 0; n_bad = 0; mon_en = 1'b0;
    rst_na = 1'b0; rst_nb = 1'b0;
    ifa.opcode = OP_R_TYPE; ifa.mem_ready = 1'b0;
    ifb.opcode = OP_LOAD;   ifb.mem_ready = 1'b0;

    issue(OP_R_TYPE, 0, 0);
    issue(OP_LOAD, 0, 3);
    issue(OP_STORE, 0, 2);
    issue(OP_JAL, 0, 0);
    for (int i = 0; i < N_RANDOM; i++) begin
      logic [6:0] op;
      int         wf, wd;
      case ($urandom_range(0, 4))
        0:       op = OP_R_TYPE;
        1:       op = OP_I_TYPE;
        2:       op = OP_LOAD;
        3:       op = OP_STORE;
        default: op = OP_JAL;
      endcase
      wf = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
      wd = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
      issue(op, wf, wd);
    end

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset_outputs_a", 32'(outs_a), 0);
    check("reset_outputs_b", 32'(outs_b), 0);
    @(posedge clk); #2;
    rst_na = 1'b1;
    mon_en = 1'b1;
    @(negedge clk); #1;
    check("first_req_after_reset", 32'({ifa.mem_req, ifa.addr_src}), 32'(2'b10));

    for (int t = 0; t < 40 * (N_RANDOM + 4) && exp_q.size() != 0; t++) @(negedge clk);
    check("random_phase_drained", exp_q.size(), 0);

    // Reset in the middle of a long MEM_RD wait.
    @(posedge clk); #2;
    mon_en = 1'b0;
    rst_na = 1'b0;
    exp_q.delete(); wait_q.delete(); op_q.delete();
    op_q.push_back(OP_LOAD);
    wait_q.push_back(0);
    wait_q.push_back(30);
    @(posedge clk); #2;
    rst_na = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk); #1;
      found = ifa.mem_req && ifa.addr_src;
    end
    check("reach_mem_rd", 32'(found), 1);
    repeat (2) begin
      @(negedge clk); #1;
      check("mem_rd_wait_no_done", 32'({ifa.addr_src, ifa.instr_done}), 32'(2'b10));
    end
    @(posedge clk); #2;
    rst_na = 1'b0;
    wait_q.delete(); op_q.delete();
    op_q.push_back(7'b1111111);
    wait_q.push_back(0);
    @(negedge clk); #1;
    check("mid_rd_reset_outputs", 32'(outs_a), 0);
    @(posedge clk); #2;
    rst_na = 1'b1;
    @(negedge clk); #1;
    check("fetch_after_reset", 32'(outs_a), 32'(OUT_FETCH_GRANT));

    // Illegal opcode: trap one cycle after DECODE, sticky until reset.
    @(negedge clk); #1;
    check("decode_outputs", 32'(outs_a), 32'(OUT_DECODE));
    for (int c = 0; c < 21; c++) begin
      @(negedge clk); #1;
      check("illegal_trap_hold", 32'(outs_a), 32'(OUT_TRAP));
    end
    @(posedge clk); #2;
    rst_na = 1'b0;
    @(negedge clk); #1;
    check("trap_reset_outputs", 32'(outs_a), 0);
    @(posedge clk); #2;
    rst_na = 1'b1;
    @(negedge clk); #1;
    check("fetch_after_trap", 32'({ifa.mem_req, ifa.addr_src, ifa.illegal}), 32'(3'b100));

    // MEM_TIMEOUT=4: four low wait cycles in FETCH trap.
    @(posedge clk); #2;
    rst_nb = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); #1;
      check("b_fetch_wait", 32'({ifb.mem_req, ifb.ir_write, ifb.illegal}), 32'(3'b100));
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      check("b_fetch_timeout_trap", 32'(outs_b), 32'(OUT_TRAP_TMO));
    end
    @(posedge clk); #2;
    rst_nb = 1'b0;
    @(negedge clk); #1;
    check("b_reset_outputs", 32'(outs_b), 0);

    // Second run: ready on the 4th cycle wins; MEM_RD count restarts from 0.
    @(posedge clk); #2;
    rst_nb = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      ifb.mem_ready = (c == 4);
      @(negedge clk); #1;
      check("b_fetch_late_ready", 32'({ifb.mem_req, ifb.ir_write, ifb.illegal}),
            32'({1'b1, c == 4, 1'b0}));
      @(posedge clk); #2;
    end
    ifb.mem_ready = 1'b0;
    @(negedge clk); #1;
    check("b_decode", 32'(outs_b), 32'(OUT_DECODE));
    @(negedge clk); #1;
    check("b_mem_addr", 32'(outs_b), 32'(OUT_MEM_ADDR));
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); #1;
      check("b_mem_rd_wait", 32'({ifb.mem_req, ifb.addr_src, ifb.illegal, ifb.mem_timeout}),
            32'(4'b1100));
    end
    @(negedge clk); #1;
    check("b_mem_rd_timeout_trap", 32'(outs_b), 32'(OUT_TRAP_TMO));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, 255, maximum number of wait cycles for mem_ready before a trap (range 1..255).
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 clk  in  1  rising-edge system clock.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 opcode  in  7  instruction bits [6:0], taken from the instruction register.
REQ-006 mem_ready  in  1  memory completion strobe for the current request.
REQ-007 mem_req  out  1  memory request, held high until mem_ready is seen.
REQ-008 mem_we  out  1  write enable; valid only while mem_req=1.
REQ-009 addr_src  out  1  memory address select: 0=PC, 1=ALUOut.
REQ-010 ir_write  out  1  instruction register / oldPC load.
REQ-011 pc_write  out  1  PC load.
REQ-012 pc_src  out  1  PC source: 0=ALU result, 1=ALUOut.
REQ-013 alu_src_a  out  2  ALU A operand: 00=PC, 01=oldPC, 10=rs1.
REQ-014 alu_src_b  out  2  ALU B operand: 00=rs2, 01=imm, 10=constant 4.
REQ-015 alud  out  1  drives ALUD of the ALU decoder: 0 forces ADD, 1 selects the operation by funct3.
REQ-016 reg_write  out  1  register file write enable.
REQ-017 result_src  out  2  writeback select: 00=ALUOut, 01=memory data, 10=PC.
REQ-018 instr_done  out  1  one-cycle pulse when an instruction retires.
REQ-019 illegal  out  1  sticky trap flag.
REQ-020 mem_timeout  out  1  sticky flag: the trap was caused by a memory timeout.

Function
REQ-021 The controller SHALL be a registered-state Moore FSM. Outputs decode from state and mem_ready only. Every output not listed for a state SHALL be 0.
REQ-022 FETCH: mem_req=1, addr_src=0, a=00, b=10, alud=0. When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, go to DECODE. Otherwise stay in FETCH.
REQ-023 DECODE: a=01, b=01, alud=0 (computes the JAL target into ALUOut). Next state by opcode:
- 0110011 -> EXEC_R
- 0010011 -> EXEC_I
- 0000011 or 0100011 -> MEM_ADDR
- 1101111 -> JAL
- any other value -> TRAP
REQ-024 EXEC_R: a=10, b=00, alud=1, then ALU_WB. EXEC_I: a=10, b=01, alud=1, then ALU_WB.
REQ-025 ALU_WB: reg_write=1, result_src=00, instr_done=1, then FETCH.
REQ-026 MEM_ADDR: a=10, b=01, alud=0. Go to MEM_RD for opcode 0000011, or MEM_WR for opcode 0100011.
REQ-027 MEM_RD: mem_req=1, addr_src=1. Wait for mem_ready, then MEM_WB. MEM_WB: reg_write=1, result_src=01, instr_done=1, then FETCH.
REQ-028 MEM_WR: mem_req=1, mem_we=1, addr_src=1. When mem_ready=1: instr_done=1, go to FETCH.
REQ-029 JAL: reg_write=1, result_src=10, pc_write=1, pc_src=1, instr_done=1, then FETCH.
REQ-030 Latency in cycles with zero-wait memory (mem_ready=1 on the first request cycle):
- R-type and I-type: 4
- load: 5
- store: 4
- JAL: 3
Each cycle mem_ready is held low adds exactly 1 cycle.
REQ-031 An 8-bit wait counter SHALL clear on entry to any memory state and increment on each cycle with mem_req=1 and mem_ready=0.
REQ-032 When the wait counter reaches MEM_TIMEOUT, the FSM SHALL go to TRAP and set mem_timeout=1. mem_ready arriving in that same cycle takes priority: the transfer completes and no trap occurs.
REQ-033 TRAP: illegal=1, all other outputs 0. The FSM stays in TRAP until reset.
REQ-034 mem_ready seen while mem_req=0 SHALL be ignored.

Reset
REQ-035 While rst_n=0 at a clock edge: state becomes FETCH, the wait counter clears to 0, and illegal and mem_timeout clear to 0.
REQ-036 All outputs SHALL be 0 while rst_n=0. The first mem_req is asserted in the first cycle after rst_n=1.
REQ-037 Reset asserted mid-instruction, including mid-wait, SHALL abandon the instruction with no instr_done pulse.

Structure
REQ-038 Shared package rv_ctrl_pkg SHALL hold the state encoding, the opcode constants, and the alu_src_a, alu_src_b and result_src encodings.
REQ-039 The ALU decoder remains a separate module fed by alud; it SHALL NOT be instantiated here.
REQ-040 No sub-module is required; the wait counter stays inline.

Verification
REQ-041 R-type (opcode 0110011), zero-wait memory -> instr_done in cycle 4, alud=1 only in cycle 3, reg_write=1 only in cycle 4.
REQ-042 Load with mem_ready delayed 3 cycles in MEM_RD -> 8 cycles total, addr_src=1 throughout MEM_RD, result_src=01 on the writeback cycle.
REQ-043 Store -> mem_we=1 only in MEM_WR, reg_write never asserted, instr_done on the mem_ready cycle.
REQ-044 opcode 1111111 in DECODE -> illegal=1 from the next cycle; it stays set for 20 cycles; rst_n low for 1 cycle clears it and FETCH resumes.
REQ-045 MEM_TIMEOUT=4 with mem_ready held at 0 in FETCH -> TRAP with mem_timeout=1. A second run with mem_ready on the 4th wait cycle completes normally with no trap.
REQ-046 rst_n deasserted mid-MEM_RD -> all outputs 0 during reset, no instr_done, FETCH on the next cycle.
